// File: rtl/instr_decode_pkg.sv
// Shared opcode/function constants, field positions and classification helpers
// for the instruction-field decoder.
package instr_decode_pkg;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int SH_MSB  = 10;
  localparam int SH_LSB  = 6;
  localparam int FN_MSB  = 5;
  localparam int FN_LSB  = 0;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int JT_MSB  = 25;
  localparam int JT_LSB  = 0;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J, FMT_ILL} fmt_e;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [4:0]  rsa;
    logic [4:0]  rta;
    logic [4:0]  wta;
    logic [4:0]  shift;
    logic [31:0] imm;
    logic [25:0] jtarget;
    logic        illegal;
  } fields_t;

  function automatic fmt_e opcode_fmt(input logic [5:0] op);
    if (op == OP_RTYPE)
      return FMT_R;
    else if (op == OP_J || op == OP_JAL)
      return FMT_J;
    else if (op inside {OP_REGIMM, [OP_BEQ:OP_LUI], [OP_LB:OP_LHU], [OP_SB:OP_SW]})
      return FMT_I;
    else
      return FMT_ILL;
  endfunction

  function automatic logic func_legal(input logic [5:0] fn);
    return fn inside {FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                      FN_JR, FN_JALR, [FN_ADD:FN_NOR], FN_SLT, FN_SLTU};
  endfunction

  // ALU-immediate ops and loads write rt; stores, branches and unknowns write nothing.
  function automatic logic writes_rt(input logic [5:0] op);
    return op inside {[OP_ADDI:OP_LUI], [OP_LB:OP_LHU]};
  endfunction

  function automatic logic [31:0] imm_ext(input logic [5:0] op, input logic [15:0] imm16);
    if (op == OP_LUI)
      return {imm16, 16'h0000};
    else if (op inside {[OP_ANDI:OP_XORI]})
      return {16'h0000, imm16};
    else
      return {{16{imm16[15]}}, imm16};
  endfunction

endpackage

// File: rtl/instr_decode_if.sv
// Instruction-in / decoded-fields-out bundle between the fetch side and the decoder.
interface instr_decode_if;
  import instr_decode_pkg::*;

  logic        cnt;
  logic [31:0] inst;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [4:0]  rsa;
  logic [4:0]  rta;
  logic [4:0]  wta;
  logic [4:0]  shift;
  logic [31:0] imm;
  logic [25:0] jtarget;
  logic        valid;
  logic        illegal;

  modport master (
    output cnt, inst,
    input  opcode, func, rsa, rta, wta, shift, imm, jtarget, valid, illegal
  );

  modport slave (
    input  cnt, inst,
    output opcode, func, rsa, rta, wta, shift, imm, jtarget, valid, illegal
  );
endinterface

// File: rtl/instr_field_decode.sv
// Combinational map from an instruction word to next decoded fields.
// INSTR_DECODE_ILLEGAL_CHECK_EN enables illegal detection and NOP squashing.
module instr_field_decode
  import instr_decode_pkg::*;
#(
  parameter int unsigned RA_REG = 31
) (
  input  logic [31:0] i_inst,
  output fields_t     o_fields
);

  localparam logic [4:0] RA_W = 5'(RA_REG);

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_sh;
  logic [15:0] w_imm16;
  fmt_e        w_fmt;
  logic        w_squash;

  assign w_op    = i_inst[OP_MSB:OP_LSB];
  assign w_fn    = i_inst[FN_MSB:FN_LSB];
  assign w_rs    = i_inst[RS_MSB:RS_LSB];
  assign w_rt    = i_inst[RT_MSB:RT_LSB];
  assign w_rd    = i_inst[RD_MSB:RD_LSB];
  assign w_sh    = i_inst[SH_MSB:SH_LSB];
  assign w_imm16 = i_inst[IMM_MSB:IMM_LSB];
  assign w_fmt   = opcode_fmt(w_op);

`ifdef INSTR_DECODE_ILLEGAL_CHECK_EN
  assign w_squash = (w_fmt == FMT_ILL) || ((w_fmt == FMT_R) && !func_legal(w_fn));
`else
  assign w_squash = 1'b0;
`endif

  // Without squashing, unknown opcodes fall through to the I-type path.
  always_comb begin
    o_fields        = '0;
    o_fields.opcode = w_op;
    if (w_squash) begin
      o_fields.illegal = 1'b1;
    end else begin
      case (w_fmt)
        FMT_R: begin
          o_fields.rsa   = w_rs;
          o_fields.rta   = w_rt;
          o_fields.wta   = (w_fn == FN_JR) ? 5'd0 : w_rd;
          o_fields.shift = w_sh;
          o_fields.func  = w_fn;
        end
        FMT_J: begin
          o_fields.jtarget = i_inst[JT_MSB:JT_LSB];
          o_fields.wta     = (w_op == OP_JAL) ? RA_W : 5'd0;
        end
        default: begin
          o_fields.rsa = w_rs;
          o_fields.rta = w_rt;
          o_fields.wta = writes_rt(w_op) ? w_rt : 5'd0;
          o_fields.imm = imm_ext(w_op, w_imm16);
        end
      endcase
    end
  end

endmodule

// File: rtl/instr_decode.sv
// Registered instruction-field decoder: captures decoded fields when cnt=1.
// INSTR_DECODE_ILLEGAL_CHECK_EN enables illegal detection and NOP squashing.
module instr_decode
  import instr_decode_pkg::*;
#(
  parameter int unsigned RA_REG = 31
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_decode_if.slave bus
);

  fields_t w_next;
  fields_t r_fields;
  logic    r_valid;

  instr_field_decode #(
    .RA_REG (RA_REG)
  ) u_field_decode (
    .i_inst   (bus.inst),
    .o_fields (w_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fields <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= bus.cnt;
      if (bus.cnt)
        r_fields <= w_next;
    end
  end

  assign bus.opcode  = r_fields.opcode;
  assign bus.func    = r_fields.func;
  assign bus.rsa     = r_fields.rsa;
  assign bus.rta     = r_fields.rta;
  assign bus.wta     = r_fields.wta;
  assign bus.shift   = r_fields.shift;
  assign bus.imm     = r_fields.imm;
  assign bus.jtarget = r_fields.jtarget;
  assign bus.illegal = r_fields.illegal;
  assign bus.valid   = r_valid;

endmodule

// File: tb/tb_instr_decode.sv
// Directed-vector bench for instr_decode; illegal-case expectations follow
// whether INSTR_DECODE_ILLEGAL_CHECK_EN is defined.
module tb_instr_decode;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  instr_decode_if bus ();

  instr_decode #(
    .RA_REG (31)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag,
                           input logic [5:0] e_op, input logic [5:0] e_fn,
                           input logic [4:0] e_rs, input logic [4:0] e_rt,
                           input logic [4:0] e_wt, input logic [4:0] e_sh,
                           input logic [31:0] e_imm, input logic [25:0] e_jt,
                           input logic e_valid, input logic e_ill);
    chk({tag, ".opcode"},  32'(bus.opcode),  32'(e_op));
    chk({tag, ".func"},    32'(bus.func),    32'(e_fn));
    chk({tag, ".rsa"},     32'(bus.rsa),     32'(e_rs));
    chk({tag, ".rta"},     32'(bus.rta),     32'(e_rt));
    chk({tag, ".wta"},     32'(bus.wta),     32'(e_wt));
    chk({tag, ".shift"},   32'(bus.shift),   32'(e_sh));
    chk({tag, ".imm"},     bus.imm,          e_imm);
    chk({tag, ".jtarget"}, 32'(bus.jtarget), 32'(e_jt));
    chk({tag, ".valid"},   32'(bus.valid),   32'(e_valid));
    chk({tag, ".illegal"}, 32'(bus.illegal), 32'(e_ill));
    $display("vec %-8s inst=%h op=%h fn=%h rs=%0d rt=%0d wt=%0d sh=%0d imm=%h jt=%h v=%b ill=%b",
             tag, bus.inst, bus.opcode, bus.func, bus.rsa, bus.rta, bus.wta,
             bus.shift, bus.imm, bus.jtarget, bus.valid, bus.illegal);
  endtask

  task automatic apply(input logic [31:0] word, input logic en);
    @(negedge clk);
    bus.inst = word;
    bus.cnt  = en;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec    = 0;
    n_miss   = 0;
    rst_n    = 1'b0;
    bus.cnt  = 1'b0;
    bus.inst = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_all("rst0", 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 26'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // add $3,$1,$2 loaded, then reset asserted mid-cycle
    apply(32'h00221820, 1'b1);
    check_all("add_pre", 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0, 26'h0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("rst_mid", 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 26'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    apply(32'h00221820, 1'b1);
    check_all("add", 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0, 26'h0, 1'b1, 1'b0);
    apply(32'h000521C0, 1'b1);
    check_all("sll", 6'h00, 6'h00, 5'd0, 5'd5, 5'd4, 5'd7, 32'h0, 26'h0, 1'b1, 1'b0);
    apply(32'h03E02808, 1'b1);
    check_all("jr", 6'h00, 6'h08, 5'd31, 5'd0, 5'd0, 5'd0, 32'h0, 26'h0, 1'b1, 1'b0);
    apply(32'h2128FFFF, 1'b1);
    check_all("addi", 6'h08, 6'h00, 5'd9, 5'd8, 5'd8, 5'd0, 32'hFFFFFFFF, 26'h0, 1'b1, 1'b0);
    apply(32'h3083FFFF, 1'b1);
    check_all("andi", 6'h0C, 6'h00, 5'd4, 5'd3, 5'd3, 5'd0, 32'h0000FFFF, 26'h0, 1'b1, 1'b0);
    apply(32'h3C018000, 1'b1);
    check_all("lui", 6'h0F, 6'h00, 5'd0, 5'd1, 5'd1, 5'd0, 32'h80000000, 26'h0, 1'b1, 1'b0);
    apply(32'h8FA8FFF0, 1'b1);
    check_all("lw", 6'h23, 6'h00, 5'd29, 5'd8, 5'd8, 5'd0, 32'hFFFFFFF0, 26'h0, 1'b1, 1'b0);
    apply(32'hAFA20004, 1'b1);
    check_all("sw", 6'h2B, 6'h00, 5'd29, 5'd2, 5'd0, 5'd0, 32'h00000004, 26'h0, 1'b1, 1'b0);
    apply(32'h1109FFFE, 1'b1);
    check_all("beq", 6'h04, 6'h00, 5'd8, 5'd9, 5'd0, 5'd0, 32'hFFFFFFFE, 26'h0, 1'b1, 1'b0);
    apply(32'h08000040, 1'b1);
    check_all("j", 6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 26'h0000040, 1'b1, 1'b0);
    apply(32'h0C100000, 1'b1);
    check_all("jal", 6'h03, 6'h00, 5'd0, 5'd0, 5'd31, 5'd0, 32'h0, 26'h0100000, 1'b1, 1'b0);

    // cnt=0: fields hold the jal decode, only valid drops
    apply(32'hFFFFFFFF, 1'b0);
    check_all("hold", 6'h03, 6'h00, 5'd0, 5'd0, 5'd31, 5'd0, 32'h0, 26'h0100000, 1'b0, 1'b0);
    apply(32'h00000000, 1'b0);
    check_all("hold2", 6'h03, 6'h00, 5'd0, 5'd0, 5'd31, 5'd0, 32'h0, 26'h0100000, 1'b0, 1'b0);

`ifdef INSTR_DECODE_ILLEGAL_CHECK_EN
    apply(32'hFC221234, 1'b1);
    check_all("ill_op", 6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 26'h0, 1'b1, 1'b1);
    apply(32'h00221801, 1'b1);
    check_all("ill_fn", 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 26'h0, 1'b1, 1'b1);
`else
    apply(32'hFC221234, 1'b1);
    check_all("ill_op", 6'h3F, 6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 32'h00001234, 26'h0, 1'b1, 1'b0);
    apply(32'h00221801, 1'b1);
    check_all("ill_fn", 6'h00, 6'h01, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0, 26'h0, 1'b1, 1'b0);
`endif

    // legal decode after an illegal one clears the flag
    apply(32'h00221820, 1'b1);
    check_all("add2", 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0, 26'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
# instr_decode

Registered instruction-field decoder for the 32-bit MIPS-style RISC core. It captures a fetched instruction word when enabled and splits it into opcode, function code, source/target register addresses, write-target address, shift amount, immediate and jump target. Its register-address outputs drive the register file read ports and the write-back address directly.

## Interface
Parameters:
- RA_REG, default 31: write-target address used for JAL.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cnt  in  1  decode enable; the instruction is captured only when cnt=1
- inst  in  32  instruction word
- opcode  out  6  inst[31:26]
- func  out  6  inst[5:0] for R-type, otherwise 0
- rsa  out  5  source register address
- rta  out  5  second source register address
- wta  out  5  write-target address; 0 means no write
- shift  out  5  inst[10:6] for R-type, otherwise 0
- imm  out  32  extended immediate
- jtarget  out  26  inst[25:0] for J/JAL, otherwise 0
- valid  out  1  registered copy of cnt
- illegal  out  1  unknown opcode or R-type func

## Operation
- R-type (opcode 0x00): rsa=inst[25:21], rta=inst[20:16], wta=inst[15:11], shift=inst[10:6], func=inst[5:0], imm=0. JR (func 0x08) forces wta=0.
- ALU-immediate (0x08–0x0F) and loads (0x20–0x25): rsa=rs, rta=rt, wta=rt.
- Stores (0x28–0x2B) and branches (0x01, 0x04–0x07): rsa=rs, rta=rt, wta=0.
- J (0x02): rsa=rta=wta=0, jtarget=inst[25:0]. JAL (0x03): the same, except wta=RA_REG.
- Immediate handling:
  - ANDI/ORI/XORI (0x0C–0x0E): imm is zero-extended.
  - LUI (0x0F): imm={inst[15:0],16'h0}.
  - All other I-type opcodes: imm is sign-extended.
- Unknown opcode, or an R-type func outside {0x00,0x02,0x03,0x04,0x06,0x07,0x08,0x09,0x20–0x27,0x2A,0x2B}: all field outputs are 0 (NOP) and illegal=1. The opcode output still carries inst[31:26].

## Timing
- All outputs are registered with 1-cycle latency. The values produced from inst at the rising edge where cnt=1 appear after that edge.
- cnt=0: every output except valid holds its previous value; valid drops to 0 at that edge.
- rst_n low forces every output to 0 immediately, independent of clk. This also applies mid-operation.
- Decode resumes at the first rising edge with rst_n=1 and cnt=1.
- inst changing while cnt=0 has no effect.

## Configuration
- INSTR_DECODE_ILLEGAL_CHECK_EN defined: illegal detection and NOP squashing are active as described in Operation.
- Not defined:
  - illegal is tied to 0.
  - Unknown opcodes decode as I-type with wta=0 and sign-extended imm.
  - Unknown R-type func values decode as normal R-type.

## Structure
- Package instr_decode_pkg holds:
  - opcode and function-code localparams;
  - a format enum {FMT_R, FMT_I, FMT_J, FMT_ILL};
  - the field bit-position constants.
- One combinational sub-module, instr_field_decode, maps inst to the next field values. The top level holds only the enable and reset registers.

## Test plan
- Reset: rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately. Release rst_n, then inst=0x00221820 with cnt=1 -> opcode=0, rsa=1, rta=2, wta=3, shift=0, func=0x20, valid=1.
- Shift: inst=0x000521C0 (sll $4,$5,7) -> rsa=0, rta=5, wta=4, shift=7, func=0.
- Immediate ops:
  - inst=0x2128FFFF (addi) -> rsa=9, rta=8, wta=8, imm=0xFFFFFFFF.
  - inst=0xAFA20004 (sw) -> rsa=29, rta=2, wta=0, imm=4.
- Jump: inst=0x0C100000 (jal) -> wta=31, jtarget=0x100000, rsa=rta=0.
- Hold: cnt=0 while inst changes to 0xFFFFFFFF -> fields unchanged, valid=0 after the edge.
- Illegal, with INSTR_DECODE_ILLEGAL_CHECK_EN defined: inst=0xFC000000 -> illegal=1, opcode=0x3F, all other fields 0.
